// File: rtl/fib_ctrl_pkg.sv
// Shared state encodings and default parameters for the Fibonacci sequencing controller.
package fib_ctrl_pkg;

  localparam int unsigned FIB_STATE_W          = 2;
  localparam int unsigned FIB_TICK_DIV_DEFAULT = 25000000;
  localparam int unsigned FIB_CNT_W_DEFAULT    = 25;

  typedef enum logic [FIB_STATE_W-1:0] {
    FIB_IDLE  = 2'd0,
    FIB_RUN   = 2'd1,
    FIB_PAUSE = 2'd2,
    FIB_HALT  = 2'd3
  } fib_state_e;

  localparam logic [7:0] FIB_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/fib_edge_det.sv
// Registered rising-edge detector: one register stage on the button, then a registered
// one-cycle pulse when the registered level rises.
module fib_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic btn_q;
  logic btn_prev_q;
  logic pulse_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q      <= 1'b0;
      btn_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      btn_q      <= btn;
      btn_prev_q <= btn_q;
      pulse_q    <= btn_q & ~btn_prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/fib_step_ctrl.sv
// Start/pause/single-step sequencer with step-rate prescaler and carry-driven overflow
// supervision. Define FIB_AUTOWRAP_EN to reload the datapath on overflow instead of halting.
module fib_step_ctrl
  import fib_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = FIB_TICK_DIV_DEFAULT,
  parameter int unsigned CNT_W    = FIB_CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_btn,
  input  logic                   pause_btn,
  input  logic                   step_btn,
  input  logic                   carry_in,
  output logic                   step_en,
  output logic                   load_init,
  output logic [FIB_STATE_W-1:0] state,
  output logic                   overflow,
  output logic [7:0]             step_count
);

  localparam logic [CNT_W-1:0] TickLast = CNT_W'(TICK_DIV - 1);

  logic start_pulse;
  logic pause_pulse;
  logic step_pulse;

  fib_edge_det u_start_det (
    .clk   (clk),
    .reset (reset),
    .btn   (start_btn),
    .pulse (start_pulse)
  );

  fib_edge_det u_pause_det (
    .clk   (clk),
    .reset (reset),
    .btn   (pause_btn),
    .pulse (pause_pulse)
  );

  fib_edge_det u_step_det (
    .clk   (clk),
    .reset (reset),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  fib_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             step_en_q;
  logic             load_init_q;
  logic             overflow_q;
  logic [7:0]       step_count_q;

  logic tick;
  logic issue;

  assign tick = (cnt_q == TickLast);

  // A step attempt happens only when no higher-priority event claims the cycle.
  always_comb begin
    issue = 1'b0;
    if (!start_pulse && !pause_pulse) begin
      if (state_q == FIB_RUN) begin
        issue = tick;
      end else if (state_q == FIB_PAUSE) begin
        issue = step_pulse;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FIB_IDLE;
      cnt_q        <= '0;
      step_en_q    <= 1'b0;
      load_init_q  <= 1'b0;
      overflow_q   <= 1'b0;
      step_count_q <= '0;
    end else begin
      step_en_q   <= 1'b0;
      load_init_q <= 1'b0;
      if (start_pulse) begin
        state_q      <= FIB_RUN;
        cnt_q        <= '0;
        load_init_q  <= 1'b1;
        overflow_q   <= 1'b0;
        step_count_q <= '0;
      end else begin
        case (state_q)
          FIB_RUN: begin
            if (pause_pulse) begin
              state_q <= FIB_PAUSE;
            end else if (tick) begin
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          FIB_PAUSE: begin
            if (pause_pulse) begin
              state_q <= FIB_RUN;
            end
          end
          FIB_IDLE: ;
          FIB_HALT: ;
          default: state_q <= FIB_IDLE;
        endcase

        if (issue) begin
          if (!carry_in) begin
            step_en_q <= 1'b1;
            if (step_count_q != FIB_COUNT_MAX) begin
              step_count_q <= step_count_q + 8'd1;
            end
          end else begin
            overflow_q <= 1'b1;
`ifdef FIB_AUTOWRAP_EN
            load_init_q  <= 1'b1;
            step_count_q <= '0;
`else
            state_q <= FIB_HALT;
`endif
          end
        end
      end
    end
  end

  assign step_en    = step_en_q;
  assign load_init  = load_init_q;
  assign state      = state_q;
  assign overflow   = overflow_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_fib_step_ctrl.sv
// Scoreboard bench for fib_step_ctrl with TICK_DIV = 4: stimulus pushes expected pulses,
// a negedge monitor pops and compares every step_en / load_init pulse.
module tb_fib_step_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic       pause_btn;
  logic       step_btn;
  logic       carry_in;
  logic       step_en;
  logic       load_init;
  logic [1:0] state;
  logic       overflow;
  logic [7:0] step_count;

  fib_step_ctrl #(
    .TICK_DIV (4),
    .CNT_W    (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .step_btn   (step_btn),
    .carry_in   (carry_in),
    .step_en    (step_en),
    .load_init  (load_init),
    .state      (state),
    .overflow   (overflow),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          ld;
    logic [1:0]  st;
    bit          ovf;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic void expect_pulse(input int unsigned c, input bit ld, input logic [1:0] st,
                                       input bit ovf, input logic [7:0] cnt);
    exp_t e;
    e.cyc = c;
    e.ld  = ld;
    e.st  = st;
    e.ovf = ovf;
    e.cnt = cnt;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (step_en || load_init) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d step_en=%0b load_init=%0b required=no pulse",
                 cyc, step_en, load_init);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc || load_init !== mon_e.ld || step_en !== !mon_e.ld ||
            state !== mon_e.st || overflow !== mon_e.ovf || step_count !== mon_e.cnt) begin
          errors++;
          $display({"FAIL pulse got cyc=%0d ld=%0b se=%0b st=%0d ovf=%0b cnt=%0d",
                    " required cyc=%0d ld=%0b se=%0b st=%0d ovf=%0b cnt=%0d"},
                   cyc, load_init, step_en, state, overflow, step_count,
                   mon_e.cyc, mon_e.ld, !mon_e.ld, mon_e.st, mon_e.ovf, mon_e.cnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  int unsigned t0, s, q, u, v, rel;

  initial begin
    reset     = 1'b1;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    step_btn  = 1'b0;
    carry_in  = 1'b0;
    #2 reset = 1'b0;
    wait_cyc(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_step_en", 32'(step_en), 32'd0);
    check("rst_load_init", 32'(load_init), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_step_count", 32'(step_count), 32'd0);
    reset = 1'b1;
    wait_cyc(4);

    // Start: load at +3, then a step every 4 cycles.
    t0 = cyc;
    start_btn = 1'b1;
    expect_pulse(t0 + 3, 1'b1, 2'd1, 1'b0, 8'd0);
    for (int k = 1; k <= 5; k++) expect_pulse(t0 + 3 + 4 * k, 1'b0, 2'd1, 1'b0, 8'(k));
    wait_cyc(t0 + 2);
    start_btn = 1'b0;
    wait_cyc(t0 + 3);
    check("start_state", 32'(state), 32'd1);
    wait_cyc(t0 + 23);
    check("run_count5", 32'(step_count), 32'd5);

    // Pause with prescaler held at 2, single step, then resume.
    pause_btn = 1'b1;
    wait_cyc(t0 + 25);
    pause_btn = 1'b0;
    wait_cyc(t0 + 26);
    check("pause_state", 32'(state), 32'd2);
    wait_cyc(t0 + 76);
    check("pause_still", 32'(state), 32'd2);
    check("pause_count", 32'(step_count), 32'd5);
    s = cyc;
    step_btn = 1'b1;
    expect_pulse(s + 3, 1'b0, 2'd2, 1'b0, 8'd6);
    wait_cyc(s + 2);
    step_btn = 1'b0;
    wait_cyc(s + 10);
    check("single_step_count", 32'(step_count), 32'd6);
    q = cyc;
    pause_btn = 1'b1;
    expect_pulse(q + 5, 1'b0, 2'd1, 1'b0, 8'd7);
    expect_pulse(q + 9, 1'b0, 2'd1, 1'b0, 8'd8);
    wait_cyc(q + 2);
    pause_btn = 1'b0;
    wait_cyc(q + 3);
    check("resume_state", 32'(state), 32'd1);

    // Overflow at the tick of q+13.
    wait_cyc(q + 10);
    carry_in = 1'b1;
`ifdef FIB_AUTOWRAP_EN
    expect_pulse(q + 13, 1'b1, 2'd1, 1'b1, 8'd0);
    wait_cyc(q + 13);
    check("wrap_state", 32'(state), 32'd1);
    check("wrap_overflow", 32'(overflow), 32'd1);
    carry_in = 1'b0;
    u = cyc;
`else
    wait_cyc(q + 13);
    check("halt_state", 32'(state), 32'd3);
    check("halt_overflow", 32'(overflow), 32'd1);
    check("halt_count", 32'(step_count), 32'd8);
    check("halt_step_en", 32'(step_en), 32'd0);
    step_btn  = 1'b1;
    pause_btn = 1'b1;
    wait_cyc(q + 15);
    step_btn  = 1'b0;
    pause_btn = 1'b0;
    wait_cyc(q + 30);
    check("halt_hold_state", 32'(state), 32'd3);
    check("halt_hold_count", 32'(step_count), 32'd8);
    check("halt_hold_overflow", 32'(overflow), 32'd1);
    carry_in = 1'b0;
    u = cyc;
`endif

    // Restart clears overflow and count.
    start_btn = 1'b1;
    expect_pulse(u + 3, 1'b1, 2'd1, 1'b0, 8'd0);
    expect_pulse(u + 7, 1'b0, 2'd1, 1'b0, 8'd1);
    wait_cyc(u + 2);
    start_btn = 1'b0;
    wait_cyc(u + 3);
    check("restart_overflow", 32'(overflow), 32'd0);
    wait_cyc(u + 5);
    pause_btn = 1'b1;
    wait_cyc(u + 7);
    pause_btn = 1'b0;
    wait_cyc(u + 9);
    check("pause2_state", 32'(state), 32'd2);

    // Simultaneous start and pause edges in PAUSE: start wins.
    wait_cyc(u + 12);
    v = cyc;
    start_btn = 1'b1;
    pause_btn = 1'b1;
    expect_pulse(v + 3, 1'b1, 2'd1, 1'b0, 8'd0);
    expect_pulse(v + 7, 1'b0, 2'd1, 1'b0, 8'd1);
    wait_cyc(v + 2);
    start_btn = 1'b0;
    pause_btn = 1'b0;
    wait_cyc(v + 5);
    check("start_beats_pause", 32'(state), 32'd1);

    // Asynchronous reset between ticks.
    wait_cyc(v + 9);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_count", 32'(step_count), 32'd0);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    check("async_rst_step_en", 32'(step_en), 32'd0);
    check("async_rst_load_init", 32'(load_init), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    rel = cyc;
    wait_cyc(rel + 20);
    check("post_rst_idle", 32'(state), 32'd0);
    check("post_rst_count", 32'(step_count), 32'd0);

    wait_cyc(cyc + 2);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_step_ctrl.md
# fib_step_ctrl

Sequencing controller for the Fibonacci datapath (8-bit previous/current registers plus adder). Replaces the free-running enable with a start/pause/single-step FSM, a programmable step-rate prescaler and overflow supervision driven by the adder carry-out. It emits a one-cycle `step_en` and a one-cycle `load_init` that the datapath registers consume.

## Interface
- `TICK_DIV`, 25000000: clock cycles between automatic steps in RUN; must be ≥ 2
- `CNT_W`, 25: prescaler width; must satisfy 2^CNT_W ≥ TICK_DIV
- `clk`  in  1  system clock; all logic on posedge
- `reset`  in  1  asynchronous, active-low reset
- `start_btn`  in  1  synchronous level; a rising edge means start or restart
- `pause_btn`  in  1  synchronous level; a rising edge toggles RUN/PAUSE
- `step_btn`  in  1  synchronous level; a rising edge requests a single step while in PAUSE
- `carry_in`  in  1  adder carry-out for the current previous + current
- `step_en`  out  1  one-cycle pulse: datapath advances
- `load_init`  out  1  one-cycle pulse: datapath loads previous = 0, current = 1
- `state`  out  2  FSM state (IDLE = 0, RUN = 1, PAUSE = 2, HALT = 3)
- `overflow`  out  1  sticky flag; set when a step is refused or wrapped because `carry_in` = 1
- `step_count`  out  8  steps issued since the last load; saturates at 255

## Operation
- **Reset:**
  - `state` = IDLE, prescaler = 0.
  - `step_en` = 0, `load_init` = 0, `overflow` = 0, `step_count` = 0.
- **Edge detection:** each button is registered once and compared with its previous sample. Each rising edge produces one internal pulse.
- **Event priority** when several events fall in the same cycle: start > pause > step > prescaler tick. Only the highest-priority event acts; lower ones are dropped.
- **Start:** accepted in any state.
  - Pulses `load_init`.
  - Clears `step_count`, `overflow` and the prescaler.
  - Moves to RUN.
- **RUN:**
  - Prescaler counts 0 to TICK_DIV-1, then wraps to 0 and raises the tick.
  - On tick with `carry_in` = 0: pulse `step_en` and increment `step_count`.
  - On tick with `carry_in` = 1: no `step_en`; set `overflow`; go to HALT.
  - A pause edge goes to PAUSE. The prescaler value is held.
- **PAUSE:**
  - The prescaler is frozen.
  - A step edge with `carry_in` = 0 pulses `step_en` and increments `step_count`.
  - A step edge with `carry_in` = 1 sets `overflow` and goes to HALT.
  - A pause edge returns to RUN and resumes from the held prescaler value.
- **HALT:** all events except start are ignored. `step_en` stays at 0.
- **IDLE:** only start is acted on.
- **`step_count`:** increments only on an issued `step_en`. Holds at 255.
- `step_en` and `load_init` are never asserted in the same cycle.

## Timing
- All outputs are registered.
- **Button latency:** a button rising at sampled edge N gives an internal pulse at N+1. The resulting `step_en`, `load_init` or state change is visible after edge N+2.
- **Tick latency:** the prescaler reaching TICK_DIV-1 at edge N gives `step_en` high for exactly the cycle after edge N+1. Steady-state step period is exactly TICK_DIV cycles.
- **Carry sampling:** `carry_in` is sampled in the same cycle as the triggering tick or step pulse. The datapath holds it stable between steps.
- **Mid-operation reset:** asserting `reset` forces the reset values immediately, independent of `clk`. Release is synchronous to the next posedge.
- `load_init` is high for one cycle. The first automatic step follows TICK_DIV cycles after the start edge takes effect.

## Configuration
- **`FIB_AUTOWRAP_EN`** changes only the overflow response in RUN and PAUSE.
- **Defined:** an overflow event pulses `load_init` instead of halting. It also sets `overflow`, clears `step_count` and keeps the current state (RUN or PAUSE). HALT is unreachable.
- **Undefined:** overflow goes to HALT as described in Operation.

## Structure
- **Shared package `fib_ctrl_pkg`** (header include) holds:
  - state encodings `FIB_IDLE`, `FIB_RUN`, `FIB_PAUSE`, `FIB_HALT`;
  - state width 2;
  - default `TICK_DIV`.
- **One sub-module, `fib_edge_det`:** a registered rising-edge pulse generator, instantiated three times (start, pause, step).
- FSM, prescaler and counters live in the top module.

## Test plan
All scenarios use TICK_DIV = 4.
- **Reset then start:** `reset` low, then high; start edge → `load_init` pulse, `state` = 1, then `step_en` every 4 cycles; `step_count` reaches 5 after 20 cycles.
- **Pause and step:** pause edge in RUN → `state` = 2 and no `step_en` for 50 cycles; step edge → exactly one `step_en`, `step_count` +1; second pause edge → RUN resumes with the held prescaler phase.
- **Overflow halts:** hold `carry_in` = 1 in RUN → at the next tick no `step_en`, `overflow` = 1, `state` = 3; further ticks, step and pause edges have no effect; start → IDLE-clear plus `load_init`, `overflow` = 0.
- **Simultaneous start and pause edges in PAUSE:** start wins; `load_init` pulses, `state` = 1, pause is ignored.
- **Mid-run reset:** assert `reset` between ticks → all outputs at reset values immediately; no `step_en` until a new start.
- **`FIB_AUTOWRAP_EN` defined:** `carry_in` = 1 at a tick → `load_init` pulse, `overflow` = 1, `step_count` = 0, `state` stays 1.
